// File: rtl/time_set_editor_if.sv
// ============================================================================
// time_set_editor_if : set-time bus between the clock core and the set editor
// Rev 1.0
// ============================================================================
`default_nettype none

interface time_set_editor_if;
    // Running time from the clock core, BCD
    logic [3:0] CUR_SEC1;
    logic [3:0] CUR_SEC0;
    logic [3:0] CUR_MIN1;
    logic [3:0] CUR_MIN0;
    logic [3:0] CUR_HOUR1;
    logic [3:0] CUR_HOUR0;
    logic [3:0] CUR_DAY1;
    logic [3:0] CUR_DAY0;
    // Edited set time, BCD, plus the field under edit for display blinking
    logic [3:0] SSEC1;
    logic [3:0] SSEC0;
    logic [3:0] SMIN1;
    logic [3:0] SMIN0;
    logic [3:0] SHOUR1;
    logic [3:0] SHOUR0;
    logic [3:0] SDAY1;
    logic [3:0] SDAY0;
    logic [1:0] FIELD;

    // Clock-core side: publishes running time, consumes set time
    modport master (
        output CUR_SEC1, CUR_SEC0, CUR_MIN1, CUR_MIN0,
               CUR_HOUR1, CUR_HOUR0, CUR_DAY1, CUR_DAY0,
        input  SSEC1, SSEC0, SMIN1, SMIN0,
               SHOUR1, SHOUR0, SDAY1, SDAY0, FIELD
    );

    // Editor side
    modport slave (
        input  CUR_SEC1, CUR_SEC0, CUR_MIN1, CUR_MIN0,
               CUR_HOUR1, CUR_HOUR0, CUR_DAY1, CUR_DAY0,
        output SSEC1, SSEC0, SMIN1, SMIN0,
               SHOUR1, SHOUR0, SDAY1, SDAY0, FIELD
    );
endinterface

`default_nettype wire

// File: rtl/time_set_editor.sv
// ============================================================================
// time_set_editor : debounced-pushbutton editor for the BCD set-time fields
// Rev 1.0
// ============================================================================
`default_nettype none

module time_set_editor #(
    parameter int DEB_CYCLES = 500000
) (
    input  wire logic           CLK,
    input  wire logic           RSTN,
    input  wire logic           SET,
    input  wire logic           KEY3,
    input  wire logic           KEY2,
    input  wire logic           KEY1,
    time_set_editor_if.slave    ts
);

    localparam int            CW    = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] C_DEB = CW'(DEB_CYCLES);

    localparam logic [3:0] C_SYNC_RST = 4'b0111;   // SET low, keys released
    localparam int         C_SET_BIT  = 3;

    typedef enum logic [1:0] {
        DEB_REL   = 2'd0,
        DEB_PWAIT = 2'd1,
        DEB_PRS   = 2'd2,
        DEB_RWAIT = 2'd3
    } deb_state_t;

    typedef enum logic [0:0] {
        MODE_IDLE = 1'b0,
        MODE_EDIT = 1'b1
    } mode_t;

    // ------------------------------------------------------------------------
    // Two-flop synchronizers: bit 3 = SET, bits 2..0 = KEY3..KEY1
    // ------------------------------------------------------------------------
    logic [3:0] sync1_q, sync1_d;
    logic [3:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = {SET, KEY3, KEY2, KEY1};
        sync2_d = sync1_q;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            sync1_q <= C_SYNC_RST;
            sync2_q <= C_SYNC_RST;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    // ------------------------------------------------------------------------
    // Per-key debounce; key_press[2]=KEY3, [1]=KEY2, [0]=KEY1
    // ------------------------------------------------------------------------
    logic [2:0] key_press;

    generate
        for (genvar k = 0; k < 3; k++) begin : g_deb
            deb_state_t    state_q, state_d;
            logic [CW-1:0] cnt_q, cnt_d;
            logic [CW-1:0] cnt_inc;
            logic          press_q, press_d;
            logic          key_low;

            assign key_low  = ~sync2_q[k];
            // Saturating so a stuck key can never wrap into a false event
            assign cnt_inc  = (cnt_q == C_DEB) ? cnt_q : cnt_q + CW'(1);
            assign key_press[k] = press_q;

            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                press_d = 1'b0;
                unique case (state_q)
                    DEB_REL: begin
                        if (key_low) begin
                            state_d = DEB_PWAIT;
                            cnt_d   = '0;
                        end
                    end
                    DEB_PWAIT: begin
                        if (!key_low) begin
                            state_d = DEB_REL;
                            cnt_d   = '0;
                        end else if (cnt_inc >= C_DEB) begin
                            state_d = DEB_PRS;
                            cnt_d   = '0;
                            press_d = 1'b1;
                        end else begin
                            cnt_d   = cnt_inc;
                        end
                    end
                    DEB_PRS: begin
                        if (!key_low) begin
                            state_d = DEB_RWAIT;
                            cnt_d   = '0;
                        end
                    end
                    DEB_RWAIT: begin
                        if (key_low) begin
                            state_d = DEB_PRS;
                            cnt_d   = '0;
                        end else if (cnt_inc >= C_DEB) begin
                            state_d = DEB_REL;
                            cnt_d   = '0;
                        end else begin
                            cnt_d   = cnt_inc;
                        end
                    end
                endcase
            end

            always_ff @(posedge CLK or negedge RSTN) begin
                if (!RSTN) begin
                    state_q <= DEB_REL;
                    cnt_q   <= '0;
                    press_q <= 1'b0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    press_q <= press_d;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Field arithmetic on the selected two-digit BCD value
    // Field index: 0=SEC 1=MIN 2=HOUR 3=DAY; each entry is {tens, ones}
    // ------------------------------------------------------------------------
    function automatic logic [7:0] to_bcd(input logic [7:0] x);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(x / 8'd10);
        ones = 4'(x % 8'd10);
        return {tens, ones};
    endfunction

    logic [3:0][7:0] sval_q, sval_d;
    logic [1:0]      field_q, field_d;
    mode_t           mode_q, mode_d;

    logic [3:0][7:0] cur_val;
    logic [7:0]      sel_bcd;
    logic [7:0]      sel_v;
    logic            sel_bad;
    logic [7:0]      v_min, v_max;
    logic [7:0]      inc_v, dec_v;
    logic            set_sync;

    assign cur_val = {{ts.CUR_DAY1,  ts.CUR_DAY0},
                      {ts.CUR_HOUR1, ts.CUR_HOUR0},
                      {ts.CUR_MIN1,  ts.CUR_MIN0},
                      {ts.CUR_SEC1,  ts.CUR_SEC0}};

    assign set_sync = sync2_q[C_SET_BIT];

    always_comb begin
        sel_bcd = sval_q[field_q];
        sel_bad = (sel_bcd[7:4] > 4'd9) || (sel_bcd[3:0] > 4'd9);
        sel_v   = 8'(sel_bcd[7:4]) * 8'd10 + 8'(sel_bcd[3:0]);
        v_min   = 8'd0;
        v_max   = 8'd59;
        unique case (field_q)
            2'd0, 2'd1: begin v_min = 8'd0; v_max = 8'd59; end
            2'd2:       begin v_min = 8'd0; v_max = 8'd23; end
            2'd3:       begin v_min = 8'd1; v_max = 8'd31; end
        endcase
        // Digits that are not BCD make the whole value out of range
        inc_v = (sel_bad || sel_v >= v_max) ? v_min : sel_v + 8'd1;
        dec_v = (sel_bad || sel_v <= v_min || sel_v > v_max) ? v_max : sel_v - 8'd1;
    end

    // ------------------------------------------------------------------------
    // Mode FSM and edit register update
    // ------------------------------------------------------------------------
    always_comb begin
        mode_d  = mode_q;
        field_d = field_q;
        sval_d  = sval_q;
        unique case (mode_q)
            MODE_IDLE: begin
                if (set_sync) begin
                    mode_d  = MODE_EDIT;
                    field_d = 2'd0;
                    sval_d  = cur_val;
                end
            end
            MODE_EDIT: begin
                if (!set_sync) begin
                    mode_d = MODE_IDLE;
                end else if (key_press[2]) begin
                    field_d = field_q + 2'd1;
                end else if (key_press[1]) begin
                    sval_d[field_q] = to_bcd(inc_v);
                end else if (key_press[0]) begin
                    sval_d[field_q] = to_bcd(dec_v);
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            mode_q  <= MODE_IDLE;
            field_q <= 2'd0;
            sval_q  <= {8'h01, 8'h00, 8'h00, 8'h00};
        end else begin
            mode_q  <= mode_d;
            field_q <= field_d;
            sval_q  <= sval_d;
        end
    end

    assign ts.SSEC1  = sval_q[0][7:4];
    assign ts.SSEC0  = sval_q[0][3:0];
    assign ts.SMIN1  = sval_q[1][7:4];
    assign ts.SMIN0  = sval_q[1][3:0];
    assign ts.SHOUR1 = sval_q[2][7:4];
    assign ts.SHOUR0 = sval_q[2][3:0];
    assign ts.SDAY1  = sval_q[3][7:4];
    assign ts.SDAY0  = sval_q[3][3:0];
    assign ts.FIELD  = field_q;

endmodule

`default_nettype wire
